// File: rtl/irq_sched.sv
// irq_sched: port-mapped 8-source priority interrupt scheduler for the KR580 core.
// Define IRQ_NESTED_EN to let higher-priority sources preempt an in-service one.
module irq_sched #(
   parameter logic [15:0] BASE      = 16'h00F0,
   parameter logic [15:0] TIMER_DIV = 16'd50000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] address,
   input  logic [7:0]  out,
   input  logic        port_rd,
   input  logic        port_we,
   input  logic        iff1,
   input  logic        inta,
   input  logic [6:0]  src,
   output logic        irq,
   output logic [2:0]  vect,
   output logic [7:0]  pin
);

   // Handshake: in REQ, irq is held high with vect frozen until the CPU
   // pulses inta (accept) or the request becomes invalid (withdraw).
   typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

   state_t      state, state_n;
   logic [7:0]  mask, pending, isr;
   logic [7:0]  pend_n, isr_n;
   logic [15:0] timer;
   logic        timer_hit;
   logic        wr_mask, wr_pend, eoi;
   logic [7:0]  allow, cand;
   logic [2:0]  cand_idx;
   logic        take, ack, withdraw;
   logic        unused_rd;

   assign unused_rd = port_rd;

   assign wr_mask   = port_we && (address == BASE);
   assign wr_pend   = port_we && (address == BASE + 16'd1);
   assign eoi       = port_we && (address == BASE + 16'd2);
   assign timer_hit = (timer == 16'd0);

`ifdef IRQ_NESTED_EN
   // Only sources strictly above the most urgent in-service one may preempt.
   assign allow = (isr == 8'h00) ? 8'hFF : ((isr & (~isr + 8'd1)) - 8'd1);
`else
   assign allow = (isr == 8'h00) ? 8'hFF : 8'h00;
`endif

   assign cand = pending & mask & allow;

   always_comb begin
      cand_idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (cand[i]) cand_idx = i[2:0];
      end
   end

   always_comb begin
      state_n  = state;
      take     = 1'b0;
      ack      = 1'b0;
      withdraw = 1'b0;
      case (state)
         IDLE: begin
            if (iff1 && (cand != 8'h00)) begin
               take    = 1'b1;
               state_n = REQ;
            end
         end
         REQ: begin
            if (!iff1 || !pending[vect] || !mask[vect]) begin
               withdraw = 1'b1;
               state_n  = IDLE;
            end else if (inta) begin
               ack     = 1'b1;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Event sets are applied last so a same-edge clear never loses an event.
   always_comb begin
      pend_n = pending;
      if (wr_pend) pend_n = pend_n & ~out;
      if (ack) pend_n[vect] = 1'b0;
      pend_n = pend_n | {timer_hit, src};
      isr_n = isr;
      if (eoi) isr_n = isr & (isr - 8'd1);
      if (ack) isr_n[vect] = 1'b1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         mask    <= 8'h00;
         pending <= 8'h00;
         isr     <= 8'h00;
         vect    <= 3'd0;
         timer   <= TIMER_DIV - 16'd1;
      end else begin
         state   <= state_n;
         pending <= pend_n;
         isr     <= isr_n;
         if (wr_mask) mask <= out;
         if (take) vect <= cand_idx;
         timer <= timer_hit ? (TIMER_DIV - 16'd1) : (timer - 16'd1);
      end
   end

   assign irq = (state == REQ);

   always_comb begin
      pin = 8'hFF;
      if (address == BASE)              pin = mask;
      else if (address == BASE + 16'd1) pin = pending;
      else if (address == BASE + 16'd2) pin = isr;
      else if (address == BASE + 16'd3) pin = 8'h5A;
   end

endmodule

// File: tb/tb_irq_sched.sv
// Self-checking bench for irq_sched with a behavioural reference model.
// Build with +define+IRQ_NESTED_EN to exercise the nested variant.
module tb_irq_sched;

   localparam logic [15:0] BASE = 16'h00F0;
   localparam int TDIV = 10;

   logic        clock, reset;
   logic [15:0] address;
   logic [7:0]  out;
   logic        port_rd, port_we, iff1, inta;
   logic [6:0]  src;
   logic        irq;
   logic [2:0]  vect;
   logic [7:0]  pin;

   int errors = 0;
   int checks = 0;
   int cyc_cnt = 0;

   logic [7:0] m_mask, m_pend, m_isr;
   bit         m_req;
   logic [2:0] m_vect;
   int         m_edges;

   irq_sched #(.BASE(BASE), .TIMER_DIV(16'(TDIV))) dut (
      .clock(clock), .reset(reset), .address(address), .out(out),
      .port_rd(port_rd), .port_we(port_we), .iff1(iff1), .inta(inta),
      .src(src), .irq(irq), .vect(vect), .pin(pin)
   );

   // clock / reset block
   initial clock = 1'b0;
   always #5 clock = ~clock;
   always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

   // reference model: priority scheduler described by its register rules
   function automatic bit allowed(input int i);
      if (m_isr == 8'h00) return 1'b1;
`ifdef IRQ_NESTED_EN
      for (int j = 0; j <= i; j++) if (m_isr[j]) return 1'b0;
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [7:0] m_read(input logic [15:0] a);
      if (a == BASE) return m_mask;
      if (a == BASE + 16'd1) return m_pend;
      if (a == BASE + 16'd2) return m_isr;
      if (a == BASE + 16'd3) return 8'h5A;
      return 8'hFF;
   endfunction

   task automatic model_step();
      logic [7:0] cand, np, ni;
      bit fire, wd, ack, found;
      if (reset) begin
         m_mask = 0; m_pend = 0; m_isr = 0; m_req = 0; m_vect = 0; m_edges = 0;
         return;
      end
      m_edges = m_edges + 1;
      fire = (m_edges % TDIV) == 0;
      cand = 8'h00;
      for (int i = 0; i < 8; i++)
         if (m_pend[i] && m_mask[i] && allowed(i)) cand[i] = 1'b1;
      wd  = m_req && (!iff1 || !m_pend[m_vect] || !m_mask[m_vect]);
      ack = m_req && !wd && inta;
      np = m_pend;
      if (port_we && address == BASE + 16'd1) np = np & ~out;
      if (ack) np[m_vect] = 1'b0;
      np = np | {fire, src};
      ni = m_isr;
      if (port_we && address == BASE + 16'd2) begin
         found = 0;
         for (int i = 0; i < 8; i++)
            if (!found && ni[i]) begin ni[i] = 1'b0; found = 1; end
      end
      if (ack) ni[m_vect] = 1'b1;
      if (!m_req) begin
         if (iff1 && cand != 8'h00) begin
            found = 0;
            for (int i = 0; i < 8; i++)
               if (!found && cand[i]) begin m_vect = 3'(i); found = 1; end
            m_req = 1;
         end
      end else if (wd || ack) begin
         m_req = 0;
      end
      if (port_we && address == BASE) m_mask = out;
      m_pend = np;
      m_isr  = ni;
   endtask

   initial begin
      forever begin
         @(posedge clock or posedge reset);
         model_step();
      end
   end

   // driver tasks (all start and end just after a falling edge)
   task automatic wait_n(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic wr_reg(input int k, input logic [7:0] d);
      address = BASE + 16'(k); out = d; port_we = 1'b1;
      @(negedge clock);
      port_we = 1'b0;
   endtask

   task automatic pulse(input logic [6:0] s);
      src = s;
      @(negedge clock);
      src = 7'h00;
   endtask

   task automatic do_ack();
      inta = 1'b1;
      @(negedge clock);
      inta = 1'b0;
   endtask

   task automatic rd(input logic [15:0] a, output logic [7:0] d);
      address = a;
      #1;
      d = pin;
   endtask

   task automatic do_reset();
      src = 0; port_we = 0; inta = 0; iff1 = 0; out = 0; address = 0;
      reset = 1'b1;
      #2;
      reset = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_reset();
      logic [7:0] d;
      do_reset();
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
      checks++; if (vect !== 3'd0) begin errors++; $display("FAIL reset_vect got=%0d exp=0", vect); end
      for (int k = 0; k < 3; k++) begin
         rd(BASE + 16'(k), d);
         checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_reg%0d got=%h exp=00", k, d); end
      end
      do_ack();
      rd(BASE + 16'd2, d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL idle_inta_isr got=%h exp=00", d); end
   endtask

   task automatic test_priority();
      logic [7:0] d;
      do_reset();
      iff1 = 1'b1;
      wr_reg(0, 8'h03);
      pulse(7'h03);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL prio_latency got=%b exp=0", irq); end
      wait_n(1);
      checks++; if (irq !== 1'b1 || vect !== 3'd0) begin errors++; $display("FAIL prio_req got irq=%b vect=%0d exp irq=1 vect=0", irq, vect); end
      do_ack();
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL prio_ack_irq got=%b exp=0", irq); end
      rd(BASE + 16'd1, d);
      checks++; if ((d & 8'h7F) !== 8'h02) begin errors++; $display("FAIL prio_pending got=%h exp=02", d & 8'h7F); end
      rd(BASE + 16'd2, d);
      checks++; if (d !== 8'h01) begin errors++; $display("FAIL prio_isr got=%h exp=01", d); end
   endtask

   // continues from test_priority: isr=01, pending[1] waiting
   task automatic test_in_service();
      logic [7:0] d;
      for (int k = 0; k < 3; k++) begin
         wait_n(1);
         checks++; if (irq !== 1'b0) begin errors++; $display("FAIL insvc_block got=%b exp=0", irq); end
      end
      wr_reg(2, 8'h00);
      wait_n(1);
      checks++; if (irq !== 1'b1 || vect !== 3'd1) begin errors++; $display("FAIL eoi_rereq got irq=%b vect=%0d exp irq=1 vect=1", irq, vect); end
      do_ack();
      pulse(7'h01);
      wait_n(1);
`ifdef IRQ_NESTED_EN
      checks++; if (irq !== 1'b1 || vect !== 3'd0) begin errors++; $display("FAIL nest_preempt got irq=%b vect=%0d exp irq=1 vect=0", irq, vect); end
      do_ack();
      rd(BASE + 16'd2, d);
      checks++; if (d !== 8'h03) begin errors++; $display("FAIL nest_isr got=%h exp=03", d); end
      wr_reg(2, 8'h00);
      rd(BASE + 16'd2, d);
      checks++; if (d !== 8'h02) begin errors++; $display("FAIL nest_eoi got=%h exp=02", d); end
`else
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL flat_no_preempt got=%b exp=0", irq); end
      wr_reg(2, 8'h00);
      rd(BASE + 16'd2, d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL flat_eoi got=%h exp=00", d); end
      wait_n(1);
      checks++; if (irq !== 1'b1 || vect !== 3'd0) begin errors++; $display("FAIL flat_rereq got irq=%b vect=%0d exp irq=1 vect=0", irq, vect); end
`endif
   endtask

   task automatic test_timer();
      int prev, n;
      do_reset();
      iff1 = 1'b1;
      wr_reg(0, 8'h80);
      prev = 0;
      for (int k = 0; k < 3; k++) begin
         n = 0;
         while (irq !== 1'b1 && n < 40) begin wait_n(1); n++; end
         checks++;
         if (n >= 40) begin errors++; $display("FAIL timer_timeout req=%0d got irq=%b exp=1", k, irq); break; end
         checks++; if (vect !== 3'd7) begin errors++; $display("FAIL timer_vect got=%0d exp=7", vect); end
         if (k > 0) begin
            checks++; if (cyc_cnt - prev !== TDIV) begin errors++; $display("FAIL timer_period got=%0d exp=%0d", cyc_cnt - prev, TDIV); end
         end
         prev = cyc_cnt;
         do_ack();
         wr_reg(2, 8'h00);
      end
   endtask

   task automatic test_withdraw();
      logic [7:0] d;
      do_reset();
      iff1 = 1'b1;
      wr_reg(0, 8'h04);
      pulse(7'h04);
      wait_n(1);
      checks++; if (irq !== 1'b1 || vect !== 3'd2) begin errors++; $display("FAIL wd_req got irq=%b vect=%0d exp irq=1 vect=2", irq, vect); end
      iff1 = 1'b0;
      wait_n(1);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL wd_iff1 got=%b exp=0", irq); end
      rd(BASE + 16'd1, d);
      checks++; if (d[2] !== 1'b1) begin errors++; $display("FAIL wd_pend_kept got=%b exp=1", d[2]); end
      iff1 = 1'b1;
      wait_n(1);
      checks++; if (irq !== 1'b1 || vect !== 3'd2) begin errors++; $display("FAIL wd_represent got irq=%b vect=%0d exp irq=1 vect=2", irq, vect); end
      wr_reg(0, 8'h00);
      wait_n(1);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL wd_mask got=%b exp=0", irq); end
      wr_reg(0, 8'h04);
      wait_n(1);
      wr_reg(1, 8'h04);
      wait_n(1);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL wd_clear got=%b exp=0", irq); end
   endtask

   task automatic test_regs();
      logic [7:0] d;
      do_reset();
      src = 7'h04; address = BASE + 16'd1; out = 8'h04; port_we = 1'b1;
      @(negedge clock);
      src = 7'h00; port_we = 1'b0;
      rd(BASE + 16'd1, d);
      checks++; if (d[2] !== 1'b1) begin errors++; $display("FAIL set_wins got=%b exp=1", d[2]); end
      wr_reg(1, 8'h04);
      rd(BASE + 16'd1, d);
      checks++; if (d[2] !== 1'b0) begin errors++; $display("FAIL w1c got=%b exp=0", d[2]); end
      rd(BASE + 16'd3, d);
      checks++; if (d !== 8'h5A) begin errors++; $display("FAIL id_read got=%h exp=5a", d); end
      port_rd = 1'b1;
      rd(16'h01F0, d);
      checks++; if (d !== 8'hFF) begin errors++; $display("FAIL unmapped_01f0 got=%h exp=ff", d); end
      port_rd = 1'b0;
      rd(16'h10F3, d);
      checks++; if (d !== 8'hFF) begin errors++; $display("FAIL unmapped_10f3 got=%h exp=ff", d); end
      wr_reg(0, 8'hA5);
      rd(BASE, d);
      checks++; if (d !== 8'hA5) begin errors++; $display("FAIL mask_rw got=%h exp=a5", d); end
   endtask

   task automatic test_async_reset();
      logic [7:0] d;
      do_reset();
      iff1 = 1'b1;
      wr_reg(0, 8'h08);
      pulse(7'h08);
      wait_n(1);
      checks++; if (irq !== 1'b1 || vect !== 3'd3) begin errors++; $display("FAIL ar_req got irq=%b vect=%0d exp irq=1 vect=3", irq, vect); end
      #2 reset = 1'b1;
      #1;
      checks++; if (irq !== 1'b0 || vect !== 3'd0) begin errors++; $display("FAIL ar_out got irq=%b vect=%0d exp 0 0", irq, vect); end
      for (int k = 0; k < 3; k++) begin
         rd(BASE + 16'(k), d);
         checks++; if (d !== 8'h00) begin errors++; $display("FAIL ar_reg%0d got=%h exp=00", k, d); end
      end
      @(negedge clock);
      reset = 1'b0;
      wait_n(TDIV - 1);
      rd(BASE + 16'd1, d);
      checks++; if (d[7] !== 1'b0) begin errors++; $display("FAIL ar_timer_early got=%b exp=0", d[7]); end
      wait_n(1);
      rd(BASE + 16'd1, d);
      checks++; if (d[7] !== 1'b1) begin errors++; $display("FAIL ar_timer_fire got=%b exp=1", d[7]); end
   endtask

   task automatic test_random();
      logic [7:0] d;
      do_reset();
      for (int c = 0; c < 800; c++) begin
         checks++; if (irq !== m_req) begin errors++; $display("FAIL rnd_irq cyc=%0d got=%b exp=%b", c, irq, m_req); end
         if (m_req) begin
            checks++; if (vect !== m_vect) begin errors++; $display("FAIL rnd_vect cyc=%0d got=%0d exp=%0d", c, vect, m_vect); end
         end
         src     = ($urandom_range(0, 5) == 0) ? 7'($urandom) : 7'h00;
         iff1    = ($urandom_range(0, 9) != 0);
         inta    = iff1 && ($urandom_range(0, 2) == 0);
         port_we = ($urandom_range(0, 5) == 0);
         out     = 8'($urandom);
         address = ($urandom_range(0, 7) == 0) ? 16'h01F0 : BASE + 16'($urandom_range(0, 3));
         #1;
         checks++; if (pin !== m_read(address)) begin errors++; $display("FAIL rnd_pin cyc=%0d addr=%h got=%h exp=%h", c, address, pin, m_read(address)); end
         @(negedge clock);
      end
      port_we = 1'b0; inta = 1'b0; src = 7'h00;
   endtask

   initial begin
      reset = 1'b1; src = 0; port_we = 0; port_rd = 0; inta = 0; iff1 = 0; out = 0; address = 0;
      @(negedge clock);
      test_reset();
      test_priority();
      test_in_service();
      test_timer();
      test_withdraw();
      test_regs();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
